adder_flag_stage: RTL and testbench

- Pipeline stage directly downstream of the N-bit ripple adder/subtractor.
- Registers the adder's sum and per-bit carry chain, derives the NZCV condition flags, and presents result plus flags to the writeback stage over a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with a registered ready_o.
- Holds an architectural NZCV flag register that is updated on flag-setting results.

---
 rtl/adder_flag_stage.sv | 107 ++++++++++
 tb/tb_adder_flag_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_flag_stage.sv
// Result/flag pipeline stage behind the ripple adder/subtractor.
// Two-entry skid buffer (main M, skid K) with registered ready, NZCV derivation and architectural flag register.
module adder_flag_stage #(
  parameter int unsigned REGISTER_WIDTH = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [REGISTER_WIDTH-1:0] sum_i,
  input  logic [REGISTER_WIDTH-1:0] carry_i,
  input  logic                      op_sub_i,
  input  logic                      set_flags_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [REGISTER_WIDTH-1:0] result_o,
  output logic [3:0]                flags_o,
  output logic                      set_flags_o,
  output logic [3:0]                nzcv_o
);

  localparam int unsigned W = REGISTER_WIDTH;

  typedef struct packed {
    logic [W-1:0] sum;
    logic [3:0]   flags;
    logic         set_flags;
    logic         op_sub;
  } entry_t;

  entry_t     m_q, m_d, k_q, k_d, in_entry;
  logic       m_valid_q, m_valid_d, k_valid_q, k_valid_d;
  logic [3:0] nzcv_q, nzcv_d;
  logic       in_fire, out_fire;

  // Carry bits below the top two and the op_sub tag carry no flag information.
  logic [W-1:0] unused_carry;
  logic         unused_op_sub;
  assign unused_carry  = carry_i;
  assign unused_op_sub = m_q.op_sub ^ k_q.op_sub;

  // Input-side flag derivation; C is carry-out (no-borrow for subtraction).
  always_comb begin
    in_entry.sum       = sum_i;
    in_entry.flags     = {sum_i[W-1], (sum_i == '0), carry_i[W-1], carry_i[W-1] ^ carry_i[W-2]};
    in_entry.set_flags = set_flags_i;
    in_entry.op_sub    = op_sub_i;
  end

  assign ready_o     = !k_valid_q;
  assign valid_o     = m_valid_q;
  assign result_o    = m_q.sum;
  assign flags_o     = m_q.flags;
  assign set_flags_o = m_q.set_flags;
  assign nzcv_o      = nzcv_q;

  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;

  // Next-state for M/K occupancy and the architectural flags.
  always_comb begin
    m_valid_d = m_valid_q;
    m_d       = m_q;
    k_valid_d = k_valid_q;
    k_d       = k_q;
    nzcv_d    = nzcv_q;

    if (out_fire && m_q.set_flags) begin
      nzcv_d = m_q.flags;
    end

    // K occupied implies ready_o=0, so no input can arrive in that case.
    if (k_valid_q) begin
      if (out_fire) begin
        m_d       = k_q;
        k_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      if (!m_valid_q || out_fire) begin
        m_valid_d = 1'b1;
        m_d       = in_entry;
      end else begin
        k_valid_d = 1'b1;
        k_d       = in_entry;
      end
    end else if (out_fire) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_valid_q <= 1'b0;
      k_valid_q <= 1'b0;
      m_q       <= '0;
      k_q       <= '0;
      nzcv_q    <= 4'b0000;
    end else begin
      m_valid_q <= m_valid_d;
      k_valid_q <= k_valid_d;
      m_q       <= m_d;
      k_q       <= k_d;
      nzcv_q    <= nzcv_d;
    end
  end

endmodule

// File: tb/tb_adder_flag_stage.sv
// Bench for adder_flag_stage: directed handshake/flag steps then a randomized stream
// checked against an operand-level arithmetic model and a FIFO scoreboard.
module tb_adder_flag_stage;

  localparam int unsigned W = 64;

  logic         clk_i;
  logic         rst_n_i;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] sum_i;
  logic [W-1:0] carry_i;
  logic         op_sub_i;
  logic         set_flags_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] result_o;
  logic [3:0]   flags_o;
  logic         set_flags_o;
  logic [3:0]   nzcv_o;

  adder_flag_stage #(.REGISTER_WIDTH(W)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .sum_i       (sum_i),
    .carry_i     (carry_i),
    .op_sub_i    (op_sub_i),
    .set_flags_i (set_flags_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .result_o    (result_o),
    .flags_o     (flags_o),
    .set_flags_o (set_flags_o),
    .nzcv_o      (nzcv_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0] sum;
    logic [W-1:0] carry;
    logic [3:0]   flags;
  } gen_t;

  typedef struct {
    logic [W-1:0] sum;
    logic [3:0]   flags;
    logic         sf;
  } exp_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Operand-level model: the adder's outputs plus flags from signed/unsigned arithmetic.
  function automatic gen_t make_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    gen_t         g;
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         c;
    bb     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + (W+1)'(sub);
    g.sum  = full[W-1:0];
    c      = sub;
    for (int i = 0; i < int'(W); i++) begin
      g.carry[i] = (a[i] & bb[i]) | (c & (a[i] ^ bb[i]));
      c          = g.carry[i];
    end
    g.flags = {g.sum[W-1], g.sum == '0, full[W],
               (a[W-1] == bb[W-1]) && (g.sum[W-1] != a[W-1])};
    return g;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] s, input logic [W-1:0] c,
                       input logic sub, input logic sf);
    valid_i     = v;
    sum_i       = s;
    carry_i     = c;
    op_sub_i    = sub;
    set_flags_i = sf;
  endtask

  exp_t         exp_q[$];
  exp_t         e;
  gen_t         g;
  gen_t         cur;
  logic [3:0]   model_nzcv, model_nzcv_next;
  logic         held, acc, sub;
  logic [W-1:0] held_res;
  logic [3:0]   held_flags;
  logic         held_sf;
  int           sent;

  initial begin
    rst_n_i = 1'b0;
    ready_i = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #12;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_result", 64'(result_o), 64'd0);
    chk("rst_flags", 64'(flags_o), 64'd0);
    chk("rst_setf", 64'(set_flags_o), 64'd0);
    chk("rst_nzcv", 64'(nzcv_o), 64'd0);
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;

    // Basic pass: zero sum with carry out of top two bits -> Z,C
    ready_i = 1'b1;
    drive(1'b1, '0, 64'hC000_0000_0000_0000, 1'b0, 1'b1);
    tick();
    chk("basic_valid", 64'(valid_o), 64'd1);
    chk("basic_result", 64'(result_o), 64'd0);
    chk("basic_flags", 64'(flags_o), 64'b0110);
    chk("basic_nzcv_pre", 64'(nzcv_o), 64'd0);
    valid_i = 1'b0;
    tick();
    chk("basic_nzcv", 64'(nzcv_o), 64'b0110);
    chk("basic_drain", 64'(valid_o), 64'd0);

    // Signed overflow: N,V with C clear
    ready_i = 1'b0;
    drive(1'b1, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, 1'b0);
    tick();
    chk("ovf_flags", 64'(flags_o), 64'b1001);
    chk("ovf_c", 64'(flags_o[1]), 64'd0);
    valid_i = 1'b0;
    ready_i = 1'b1;
    tick();
    chk("ovf_nzcv_hold", 64'(nzcv_o), 64'b0110);

    // Subtract 5-3: no borrow -> C=1, not inverted
    g = make_op(64'd5, 64'd3, 1'b1);
    drive(1'b1, g.sum, g.carry, 1'b1, 1'b0);
    tick();
    chk("sub_result", 64'(result_o), 64'd2);
    chk("sub_flags", 64'(flags_o), 64'b0010);
    valid_i = 1'b0;
    tick();

    // Skid: A,B,C with ready_i low from the cycle A is presented
    ready_i = 1'b0;
    drive(1'b1, 64'd1, '0, 1'b0, 1'b0);
    tick();
    chk("skid_a_valid", 64'(valid_o), 64'd1);
    chk("skid_a_ready", 64'(ready_o), 64'd1);
    drive(1'b1, 64'd0, '0, 1'b0, 1'b0);
    tick();
    chk("skid_full_ready", 64'(ready_o), 64'd0);
    chk("skid_full_res", 64'(result_o), 64'd1);
    drive(1'b1, 64'h8000_0000_0000_0000, '0, 1'b0, 1'b0);
    tick();
    chk("skid_stall_ready", 64'(ready_o), 64'd0);
    chk("skid_stall_res", 64'(result_o), 64'd1);
    ready_i = 1'b1;
    tick();
    chk("skid_b_res", 64'(result_o), 64'd0);
    chk("skid_b_flags", 64'(flags_o), 64'b0100);
    chk("skid_b_ready", 64'(ready_o), 64'd1);
    tick();
    chk("skid_c_res", 64'(result_o), 64'h8000_0000_0000_0000);
    chk("skid_c_flags", 64'(flags_o), 64'b1000);
    chk("skid_c_valid", 64'(valid_o), 64'd1);
    valid_i = 1'b0;
    tick();
    chk("skid_empty", 64'(valid_o), 64'd0);

    // Async reset with M and K both occupied
    ready_i = 1'b0;
    drive(1'b1, 64'd7, '0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 64'd9, '0, 1'b0, 1'b1);
    tick();
    valid_i = 1'b0;
    chk("ar_pre_ready", 64'(ready_o), 64'd0);
    @(negedge clk_i);
    #2 rst_n_i = 1'b0;
    #1;
    chk("ar_valid", 64'(valid_o), 64'd0);
    chk("ar_ready", 64'(ready_o), 64'd1);
    chk("ar_nzcv", 64'(nzcv_o), 64'd0);
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    ready_i = 1'b1;
    tick();
    chk("ar_no_stale0", 64'(valid_o), 64'd0);
    tick();
    chk("ar_no_stale1", 64'(valid_o), 64'd0);

    // set_flags gating
    drive(1'b1, 64'h8000_0000_0000_0000, '0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'd0, '0, 1'b0, 1'b1);
    tick();
    chk("gate_nzcv_first", 64'(nzcv_o), 64'd0);
    chk("gate_second_flags", 64'(flags_o), 64'b0100);
    valid_i = 1'b0;
    tick();
    chk("gate_nzcv_second", 64'(nzcv_o), 64'b0100);

    // Randomized stream against the scoreboard
    model_nzcv = 4'b0100;
    held = 1'b0;
    acc  = 1'b0;
    sent = 0;
    cur  = '{default: '0};
    for (int cyc = 0; cyc < 3000 && (sent < 100 || exp_q.size() > 0); cyc++) begin
      ready_i = 1'($urandom_range(0, 1));
      if (valid_i && !acc) begin
        // source holds its pending entry
      end else if (sent < 100 && $urandom_range(0, 3) != 0) begin
        sub = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0:       cur = make_op({$urandom, $urandom}, {$urandom, $urandom}, sub);
          1:       cur = make_op(64'h7FFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 31)), 64'($urandom_range(0, 31)), sub);
          2:       cur = make_op(64'($urandom_range(0, 7)), 64'($urandom_range(0, 7)), sub);
          default: cur = make_op({$urandom, $urandom}, 64'h8000_0000_0000_0000, sub);
        endcase
        drive(1'b1, cur.sum, cur.carry, sub, 1'($urandom_range(0, 1)));
      end else begin
        drive(1'b0, 'x, 'x, 1'b0, 1'b0);
      end

      @(negedge clk_i);
      model_nzcv_next = model_nzcv;
      if (held) begin
        chk("rnd_hold_res", 64'(result_o), 64'(held_res));
        chk("rnd_hold_flags", 64'(flags_o), 64'(held_flags));
        chk("rnd_hold_sf", 64'(set_flags_o), 64'(held_sf));
      end
      if (valid_o && ready_i) begin
        chk("rnd_q_nonempty", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rnd_result", 64'(result_o), 64'(e.sum));
          chk("rnd_flags", 64'(flags_o), 64'(e.flags));
          chk("rnd_sf", 64'(set_flags_o), 64'(e.sf));
          if (e.sf) model_nzcv_next = e.flags;
        end
      end
      chk("rnd_nzcv", 64'(nzcv_o), 64'(model_nzcv));
      acc = valid_i && ready_o;
      if (acc) begin
        exp_q.push_back('{sum: cur.sum, flags: cur.flags, sf: set_flags_i});
        sent++;
      end
      held       = valid_o && !ready_i;
      held_res   = result_o;
      held_flags = flags_o;
      held_sf    = set_flags_o;
      @(posedge clk_i);
      #1;
      model_nzcv = model_nzcv_next;
    end
    chk("rnd_sent", 64'(sent), 64'd100);
    chk("rnd_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
